// File: rtl/parallel_fill_ctrl.sv
// Fill/drain sequencer for an external serial-to-parallel register bank:
// steers incoming words into consecutive slots, then offers the whole bank downstream.
module parallel_fill_ctrl #(
  parameter int NREGS = 2,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic             flush,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [NREGS-1:0] reg_we,
  output logic [SEL_W-1:0] reg_sel,
  output logic [NREGS-1:0] send_mask,
  output logic [SEL_W:0]   count
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREGS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic [SEL_W:0]   fill_cnt;

  function automatic logic [SEL_W:0] popcount(input logic [NREGS-1:0] m);
    logic [SEL_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      c = c + (SEL_W+1)'(m[i]);
    end
    return c;
  endfunction

  assign fill_cnt = popcount(mask_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    reg_we    = '0;
    reg_sel   = idx_q;
    send_mask = '0;
    count     = fill_cnt;

    unique case (state_q)
      FILL: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          reg_we         = NREGS'(1) << idx_q;
          mask_d[idx_q]  = 1'b1;
          if ((idx_q == LAST_IDX) || flush) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (flush && (mask_q != '0)) begin
          // Early drain: restart the next fill from slot 0.
          idx_d   = '0;
          state_d = FULL;
        end
      end
      FULL: begin
        send_val  = 1'b1;
        send_mask = mask_q;
        if (send_rdy) begin
          state_d = FILL;
          mask_d  = '0;
          idx_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase

    // Outputs are held inactive for the whole reset assertion, not only after the edge.
    if (reset) begin
      recv_rdy  = 1'b0;
      send_val  = 1'b0;
      reg_we    = '0;
      reg_sel   = '0;
      send_mask = '0;
      count     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_parallel_fill_ctrl.sv
// Self-checking bench for parallel_fill_ctrl (NREGS=4): word-count model plus directed literals.
module tb_parallel_fill_ctrl;

  localparam int NREGS = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             recv_val = 1'b0;
  logic             flush = 1'b0;
  logic             send_rdy = 1'b0;
  logic             recv_rdy;
  logic             send_val;
  logic [NREGS-1:0] reg_we;
  logic [SEL_W-1:0] reg_sel;
  logic [NREGS-1:0] send_mask;
  logic [SEL_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the bank is described only by how many words it holds and whether it is on offer.
  int n_words = 0;
  bit on_offer = 1'b0;

  parallel_fill_ctrl #(.NREGS(NREGS)) dut (
    .clk(clk),
    .reset(reset),
    .recv_val(recv_val),
    .recv_rdy(recv_rdy),
    .flush(flush),
    .send_val(send_val),
    .send_rdy(send_rdy),
    .reg_we(reg_we),
    .reg_sel(reg_sel),
    .send_mask(send_mask),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      n_words  = 0;
      on_offer = 1'b0;
    end else if (!on_offer) begin
      if (recv_val) begin
        n_words = n_words + 1;
        if (n_words == NREGS || flush) on_offer = 1'b1;
      end else if (flush && n_words > 0) begin
        on_offer = 1'b1;
      end
    end else if (send_rdy) begin
      on_offer = 1'b0;
      n_words  = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("m_rst_recv_rdy", 32'(recv_rdy), 0);
      check("m_rst_send_val", 32'(send_val), 0);
      check("m_rst_reg_we", 32'(reg_we), 0);
      check("m_rst_send_mask", 32'(send_mask), 0);
      check("m_rst_count", 32'(count), 0);
      check("m_rst_reg_sel", 32'(reg_sel), 0);
    end else if (!on_offer) begin
      check("m_fill_recv_rdy", 32'(recv_rdy), 1);
      check("m_fill_send_val", 32'(send_val), 0);
      check("m_fill_reg_we", 32'(reg_we), recv_val ? (32'd1 << n_words) : 32'd0);
      check("m_fill_send_mask", 32'(send_mask), 0);
      check("m_fill_count", 32'(count), 32'(n_words));
      check("m_fill_reg_sel", 32'(reg_sel), 32'(n_words));
    end else begin
      check("m_full_recv_rdy", 32'(recv_rdy), 0);
      check("m_full_send_val", 32'(send_val), 1);
      check("m_full_reg_we", 32'(reg_we), 0);
      check("m_full_send_mask", 32'(send_mask), (32'd1 << n_words) - 1);
      check("m_full_count", 32'(count), 32'(n_words));
    end
  end

  task automatic apply(input logic rv, input logic fl, input logic sr, input logic rs);
    recv_val = rv;
    flush    = fl;
    send_rdy = sr;
    reset    = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with recv_val high
    apply(1, 0, 0, 1);
    check("t1_recv_rdy", 32'(recv_rdy), 0);
    check("t1_reg_we", 32'(reg_we), 0);
    check("t1_send_val", 32'(send_val), 0);
    tick();
    apply(1, 0, 0, 1);
    tick();
    apply(0, 0, 0, 0);
    check("t1_post_recv_rdy", 32'(recv_rdy), 1);
    check("t1_post_reg_sel", 32'(reg_sel), 0);
    check("t1_post_count", 32'(count), 0);

    // 2: four back-to-back words
    apply(1, 0, 0, 0);
    check("t2_we0", 32'(reg_we), 32'h1);
    tick(); apply(1, 0, 0, 0);
    check("t2_we1", 32'(reg_we), 32'h2);
    tick(); apply(1, 0, 0, 0);
    check("t2_we2", 32'(reg_we), 32'h4);
    tick(); apply(1, 0, 0, 0);
    check("t2_we3", 32'(reg_we), 32'h8);
    tick(); apply(0, 0, 0, 0);
    check("t2_send_val", 32'(send_val), 1);
    check("t2_send_mask", 32'(send_mask), 32'hf);
    check("t2_count", 32'(count), 4);
    check("t2_recv_rdy", 32'(recv_rdy), 0);

    // 3: downstream stall, then drain
    for (int i = 0; i < 5; i++) begin
      tick(); apply(0, 0, 0, 0);
      check("t3_stall_mask", 32'(send_mask), 32'hf);
      check("t3_stall_val", 32'(send_val), 1);
    end
    apply(0, 0, 1, 0);
    tick(); apply(0, 0, 0, 0);
    check("t3_send_val", 32'(send_val), 0);
    check("t3_recv_rdy", 32'(recv_rdy), 1);
    check("t3_reg_sel", 32'(reg_sel), 0);
    check("t3_count", 32'(count), 0);

    // 4: two words then lone flush; flush while full is ignored
    apply(1, 0, 0, 0); tick();
    apply(1, 0, 0, 0); tick();
    apply(0, 1, 0, 0); tick();
    apply(0, 1, 0, 0);
    check("t4_send_val", 32'(send_val), 1);
    check("t4_send_mask", 32'(send_mask), 32'h3);
    check("t4_count", 32'(count), 2);
    tick(); apply(0, 0, 0, 0);
    check("t4_flush_ignored", 32'(send_mask), 32'h3);
    apply(0, 0, 1, 0); tick();

    // 5: flush together with a word
    apply(1, 0, 0, 0); tick();
    apply(1, 1, 0, 0);
    check("t5_reg_we", 32'(reg_we), 32'h2);
    tick(); apply(0, 0, 0, 0);
    check("t5_send_mask", 32'(send_mask), 32'h3);
    check("t5_count", 32'(count), 2);
    apply(0, 0, 1, 0); tick();

    // 6: reset pulse discards a partial fill
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0); tick();
    end
    apply(0, 0, 0, 1); tick();
    apply(0, 0, 0, 0);
    check("t6_count", 32'(count), 0);
    check("t6_send_val", 32'(send_val), 0);
    apply(1, 0, 0, 0);
    check("t6_we0", 32'(reg_we), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(); apply(1, 0, 0, 0);
    end
    check("t6_full_mask", 32'(send_mask), 32'hf);
    apply(0, 0, 1, 0); tick();

    // 7: flush on an empty bank
    apply(0, 1, 0, 0); tick();
    apply(0, 0, 0, 0);
    check("t7_send_val", 32'(send_val), 0);
    check("t7_recv_rdy", 32'(recv_rdy), 1);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

endmodule
